// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Single-issue fetch stage with stall, redirect and sticky
//            misaligned-redirect fault; one-cycle fetch-to-decode latency.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        fetch_fault
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic [31:0] r_pc_out;
    logic        r_instr_valid;
    logic        r_fetch_fault;
    logic        w_misaligned;

    assign w_misaligned = |branch_target[1:0];
    assign imem_addr    = r_pc;
    assign instruction  = r_instruction;
    assign pc_out       = r_pc_out;
    assign instr_valid  = r_instr_valid;
    assign fetch_fault  = r_fetch_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_instruction <= NOP_WORD;
            r_pc_out      <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    // A redirect wins over stall so it is never dropped.
                    if (branch_taken) begin
                        r_instruction <= NOP_WORD;
                        r_instr_valid <= 1'b0;
                        if (w_misaligned) begin
                            r_fetch_fault <= 1'b1;
                            r_state       <= S_FAULT;
                        end else begin
                            r_pc <= branch_target;
                        end
                    end else if (!stall) begin
                        r_instruction <= imem_rdata;
                        r_pc_out      <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_pc          <= r_pc + 32'd4;
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_FAULT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Self-checking bench for instruction_fetch against a behavioural
//            fetch model; includes a wrap-around instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] c_nop  = 32'h00000013;
    localparam logic [31:0] c_key  = 32'hA5A5A5A5;
    localparam logic [31:0] c_wrap = 32'hFFFFFFF8;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        fetch_fault;

    logic [31:0] w_addr2;
    logic [31:0] w_rdata2;
    logic [31:0] w_instr2;
    logic [31:0] w_pcout2;
    logic        w_valid2;
    logic        w_fault2;

    int errors;
    int checks;

    // Reference model state
    logic        m_boot;
    logic        m_halted;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;
    logic        m_valid;
    logic        m_fault;

    assign imem_rdata = imem_addr ^ c_key;
    assign w_rdata2   = w_addr2 ^ c_key;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instruction(instruction), .pc_out(pc_out),
        .instr_valid(instr_valid), .fetch_fault(fetch_fault)
    );

    instruction_fetch #(.RESET_PC(c_wrap)) dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0), .imem_addr(w_addr2),
        .imem_rdata(w_rdata2), .instruction(w_instr2), .pc_out(w_pcout2),
        .instr_valid(w_valid2), .fetch_fault(w_fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [97:0] observed();
        return {instruction, pc_out, instr_valid, fetch_fault, imem_addr};
    endfunction

    function automatic logic [97:0] expected();
        return {m_instr, m_pcout, m_valid, m_fault, m_pc};
    endfunction

    task automatic model_reset();
        m_boot = 1'b1; m_halted = 1'b0; m_pc = 32'h0;
        m_instr = c_nop; m_pcout = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
    endtask

    task automatic model_step();
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halted) begin
            if (branch_taken) begin
                m_instr = c_nop;
                m_valid = 1'b0;
                if (branch_target % 4 != 0) begin
                    m_fault  = 1'b1;
                    m_halted = 1'b1;
                end else begin
                    m_pc = branch_target;
                end
            end else if (!stall) begin
                m_instr = m_pc ^ c_key;
                m_pcout = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL reset_values got=%h want=%h", observed(), expected());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h0 || observed() !== expected()) begin
            errors++;
            $display("FAIL boot_cycle got=%h want=%h", observed(), expected());
        end
        stall = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (observed() !== expected() || pc_out !== 32'(4 * i)
                || instruction !== (32'(4 * i) ^ c_key) || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_fetch[%0d] got=%h want_pc=%h", i, observed(), 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        int budget;
        do_reset();
        tick();
        budget = 0;
        while (pc_out !== 32'h8 && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (pc_out !== 32'h8) begin
            errors++;
            $display("FAIL stall_reach got=%h want=%h", pc_out, 32'h8);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc_out !== 32'h8 || imem_addr !== 32'hC || instruction !== (32'h8 ^ c_key)
                || observed() !== expected()) begin
                errors++;
                $display("FAIL stall_hold[%0d] got=%h want=%h", i, observed(), expected());
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (pc_out !== 32'hC || instruction !== (32'hC ^ c_key) || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume got=%h want_pc=%h", observed(), 32'hC);
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || instruction !== c_nop || imem_addr !== 32'h100
            || pc_out !== 32'hC) begin
            errors++;
            $display("FAIL redirect_edge got=%h want=%h", observed(), expected());
        end
        stall = 1'b0; branch_taken = 1'b0;
        tick();
        checks++;
        if (pc_out !== 32'h100 || instruction !== (32'h100 ^ c_key) || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_target got=%h want_pc=%h", observed(), 32'h100);
        end
    endtask

    task automatic test_misaligned();
        logic [97:0] frozen;
        do_reset();
        tick();
        tick();
        tick();
        branch_taken = 1'b1; branch_target = 32'h102;
        tick();
        checks++;
        if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || instruction !== c_nop
            || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL misaligned_edge got=%h want=%h", observed(), expected());
        end
        frozen = observed();
        for (int i = 0; i < 10; i++) begin
            stall = 1'($urandom); branch_taken = 1'($urandom);
            branch_target = $urandom & 32'hFFFFFFFC;
            tick();
            checks++;
            if (observed() !== frozen || observed() !== expected()) begin
                errors++;
                $display("FAIL fault_hold[%0d] got=%h want=%h", i, observed(), frozen);
            end
        end
        stall = 1'b0; branch_taken = 1'b0;
        do_reset();
        checks++;
        if (fetch_fault !== 1'b0 || observed() !== expected()) begin
            errors++;
            $display("FAIL fault_clear got=%h want=%h", observed(), expected());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seq [3];
        seq[0] = 32'hFFFFFFF8; seq[1] = 32'hFFFFFFFC; seq[2] = 32'h00000000;
        stall = 1'b0; branch_taken = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (w_pcout2 !== seq[i] || w_fault2 !== 1'b0 || w_valid2 !== 1'b1
                || w_instr2 !== (seq[i] ^ c_key)) begin
                errors++;
                $display("FAIL wrap[%0d] got_pc=%h got_fault=%b want_pc=%h", i, w_pcout2, w_fault2, seq[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        stall = 1'b0; branch_taken = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (observed() !== expected() || instruction !== c_nop || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", observed(), expected());
        end
        rst = 1'b0;
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        tick();
        checks++;
        if (pc_out !== 32'h0 || instr_valid !== 1'b1 || observed() !== expected()) begin
            errors++;
            $display("FAIL async_reset_resume got=%h want=%h", observed(), expected());
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 5; seg++) begin
            stall = 1'b0; branch_taken = 1'b0;
            do_reset();
            for (int i = 0; i < 40; i++) begin
                stall        = ($urandom_range(0, 9) < 3);
                branch_taken = ($urandom_range(0, 9) == 0);
                branch_target = {20'h0, 10'($urandom), 2'b00};
                if ($urandom_range(0, 59) == 0) branch_target[1:0] = 2'($urandom_range(1, 3));
                tick();
                checks++;
                if (observed() !== expected()) begin
                    errors++;
                    $display("FAIL random[%0d.%0d] got=%h want=%h", seg, i, observed(), expected());
                end
            end
        end
        stall = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
